// File: rtl/ext_pkg.sv
// Shared definitions for the immediate-extension unit: mode codes, the mode
// type, the output-buffer occupancy states and the illegal-mode decode.
package ext_pkg;

    typedef logic [2:0] ext_mode_t;

    localparam ext_mode_t EXT_ZERO   = 3'd0;
    localparam ext_mode_t EXT_SIGN   = 3'd1;
    localparam ext_mode_t EXT_UPPER  = 3'd2;
    localparam ext_mode_t EXT_BRANCH = 3'd3;
    localparam ext_mode_t EXT_JUMP   = 3'd4;

    // Number of results held between the extender and the consumer.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_t;

    // Codes above JUMP have no defined extension.
    function automatic logic mode_err(input ext_mode_t mode);
        return (mode > EXT_JUMP);
    endfunction

endpackage

// File: rtl/imm_extend_pipe_if.sv
// Request/response bundle of the immediate-extension unit. The unit itself
// takes the slave view; the decode side (or a bench) takes the master view.
interface imm_extend_pipe_if #(
    parameter int DATA_W = 32,
    parameter int JTGT_W = 26
);
    logic                       in_valid;
    logic                       in_ready;
    logic [2:0]                 ExtMode;
    logic [JTGT_W-1:0]          Immediate;
    logic [DATA_W-JTGT_W-3:0]   PcHi;
    logic                       out_valid;
    logic                       out_ready;
    logic [DATA_W-1:0]          ImExtend;
    logic                       ModeErr;

    modport slave (
        input  in_valid, ExtMode, Immediate, PcHi, out_ready,
        output in_ready, out_valid, ImExtend, ModeErr
    );

    modport master (
        output in_valid, ExtMode, Immediate, PcHi, out_ready,
        input  in_ready, out_valid, ImExtend, ModeErr
    );
endinterface

// File: rtl/ext_core.sv
// Purely combinational immediate extender. Shared with the single-cycle CPU,
// so it carries no clock and no handshake.
module ext_core
    import ext_pkg::*;
#(
    parameter int IMM_W  = 16,
    parameter int DATA_W = 32,
    parameter int JTGT_W = 26
) (
    input  ext_mode_t                  i_mode,
    input  logic [JTGT_W-1:0]          i_imm,
    input  logic [DATA_W-JTGT_W-3:0]   i_pc_hi,
    output logic [DATA_W-1:0]          o_value,
    output logic                       o_mode_err
);

    logic [IMM_W-1:0]  w_imm;
    logic [DATA_W-1:0] w_zero;
    logic [DATA_W-1:0] w_sign;
    logic [DATA_W-1:0] w_upper;
    logic [DATA_W-1:0] w_branch;
    logic [DATA_W-1:0] w_jump;

    assign w_imm    = i_imm[IMM_W-1:0];
    assign w_zero   = {{(DATA_W-IMM_W){1'b0}}, w_imm};
    assign w_sign   = {{(DATA_W-IMM_W){w_imm[IMM_W-1]}}, w_imm};
    assign w_upper  = {w_imm, {(DATA_W-IMM_W){1'b0}}};
    // Word-aligned branch offset: the two top sign bits fall off.
    assign w_branch = {w_sign[DATA_W-3:0], 2'b00};
    assign w_jump   = {i_pc_hi, i_imm, 2'b00};

    // Select the extension; illegal codes yield zero flagged by o_mode_err.
    always_comb begin
        o_value    = '0;
        o_mode_err = mode_err(i_mode);
        case (i_mode)
            EXT_ZERO:   o_value = w_zero;
            EXT_SIGN:   o_value = w_sign;
            EXT_UPPER:  o_value = w_upper;
            EXT_BRANCH: o_value = w_branch;
            EXT_JUMP:   o_value = w_jump;
            default:    o_value = '0;
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate extender with valid/ready on both sides. SKID=1 keeps
// a main output register plus a skid register so in_ready is registered and
// independent of out_ready; SKID=0 uses only the main register.
module imm_extend_pipe
    import ext_pkg::*;
#(
    parameter int IMM_W  = 16,
    parameter int DATA_W = 32,
    parameter int JTGT_W = 26,
    parameter int SKID   = 1
) (
    input  logic             CLK,
    input  logic             Reset,
    imm_extend_pipe_if.slave bus
);

    occ_t              r_occ;
    occ_t              w_occ_next;
    logic [DATA_W-1:0] r_main_data;
    logic              r_main_err;
    logic [DATA_W-1:0] r_skid_data;
    logic              r_skid_err;
    logic [DATA_W-1:0] w_core_data;
    logic              w_core_err;
    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_load_main;
    logic              w_load_skid;
    logic              w_skid_to_main;

    ext_core #(
        .IMM_W  (IMM_W),
        .DATA_W (DATA_W),
        .JTGT_W (JTGT_W)
    ) u_core (
        .i_mode     (bus.ExtMode),
        .i_imm      (bus.Immediate),
        .i_pc_hi    (bus.PcHi),
        .o_value    (w_core_data),
        .o_mode_err (w_core_err)
    );

    // Reset masks the output so no transfer can complete in a reset cycle.
    assign w_out_valid = (r_occ != OCC_EMPTY) && !Reset;

    generate
        if (SKID != 0) begin : g_skid
            // Only the registered occupancy decides readiness.
            assign w_in_ready = (r_occ != OCC_TWO) && !Reset;
        end else begin : g_single
            // Single register: accept when empty or draining this cycle.
            assign w_in_ready = (!w_out_valid || bus.out_ready) && !Reset;
        end
    endgenerate

    assign w_in_fire  = bus.in_valid && w_in_ready;
    assign w_out_fire = w_out_valid && bus.out_ready;

    // Occupancy state register.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_occ <= OCC_EMPTY;
        end else begin
            r_occ <= w_occ_next;
        end
    end

    // Next occupancy and the data-path moves it implies.
    always_comb begin
        w_occ_next     = r_occ;
        w_load_main    = 1'b0;
        w_load_skid    = 1'b0;
        w_skid_to_main = 1'b0;
        case (r_occ)
            OCC_EMPTY: begin
                if (w_in_fire) begin
                    w_occ_next  = OCC_ONE;
                    w_load_main = 1'b1;
                end
            end
            OCC_ONE: begin
                if (w_in_fire && w_out_fire) begin
                    w_load_main = 1'b1;
                end else if (w_in_fire) begin
                    w_occ_next  = OCC_TWO;
                    w_load_skid = 1'b1;
                end else if (w_out_fire) begin
                    w_occ_next  = OCC_EMPTY;
                end
            end
            OCC_TWO: begin
                // in_ready is low here, so only a drain can happen.
                if (w_out_fire) begin
                    w_occ_next     = OCC_ONE;
                    w_skid_to_main = 1'b1;
                end
            end
            default: w_occ_next = OCC_EMPTY;
        endcase
    end

    // Main and skid result registers.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_main_data <= '0;
            r_main_err  <= 1'b0;
            r_skid_data <= '0;
            r_skid_err  <= 1'b0;
        end else begin
            if (w_load_main) begin
                r_main_data <= w_core_data;
                r_main_err  <= w_core_err;
            end else if (w_skid_to_main) begin
                r_main_data <= r_skid_data;
                r_main_err  <= r_skid_err;
            end
            if (w_load_skid) begin
                r_skid_data <= w_core_data;
                r_skid_err  <= w_core_err;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.ImExtend  = r_main_data;
    assign bus.ModeErr   = r_main_err;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: a SKID=1 and a SKID=0 instance share the same
// stimulus; hand-computed vectors plus a scoreboard per instance.
module tb_imm_extend_pipe;
    import ext_pkg::*;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        Reset;
    logic        in_valid;
    logic        out_ready;
    logic [2:0]  ext_mode;
    logic [25:0] imm;
    logic [3:0]  pc_hi;

    imm_extend_pipe_if #(.DATA_W(32), .JTGT_W(26)) bus_a ();
    imm_extend_pipe_if #(.DATA_W(32), .JTGT_W(26)) bus_b ();

    assign bus_a.in_valid  = in_valid;
    assign bus_a.ExtMode   = ext_mode;
    assign bus_a.Immediate = imm;
    assign bus_a.PcHi      = pc_hi;
    assign bus_a.out_ready = out_ready;
    assign bus_b.in_valid  = in_valid;
    assign bus_b.ExtMode   = ext_mode;
    assign bus_b.Immediate = imm;
    assign bus_b.PcHi      = pc_hi;
    assign bus_b.out_ready = out_ready;

    imm_extend_pipe #(.IMM_W(16), .DATA_W(32), .JTGT_W(26), .SKID(1)) dut_a (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus_a)
    );

    imm_extend_pipe #(.IMM_W(16), .DATA_W(32), .JTGT_W(26), .SKID(0)) dut_b (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus_b)
    );

    int total = 0;
    int bad   = 0;

    logic [32:0] q_a[$];
    logic [32:0] q_b[$];
    int          out_cnt[2];
    logic        prev_hold[2];
    logic [32:0] prev_data[2];

    typedef struct {
        logic [2:0]  mode;
        logic [25:0] imm;
        logic [3:0]  pc;
        logic [31:0] val;
        logic        err;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs[NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference extension written arithmetically: {ModeErr, value}.
    function automatic logic [32:0] ref_ext(input logic [2:0] m, input logic [25:0] im,
                                            input logic [3:0] pc);
        logic [15:0]        h;
        logic signed [31:0] s;
        h = im[15:0];
        s = 32'($signed(h));
        case (m)
            3'd0:    return {1'b0, 32'(h)};
            3'd1:    return {1'b0, s};
            3'd2:    return {1'b0, 32'(h) * 32'd65536};
            3'd3:    return {1'b0, 32'(s * 32'sd4)};
            3'd4:    return {1'b0, pc, im, 2'b00};
            default: return {1'b1, 32'h0};
        endcase
    endfunction

    task automatic mon_one(input int id, input logic iv, input logic ir, input logic ov,
                           input logic [31:0] d, input logic e);
        logic [32:0] exp;
        if (Reset) begin
            chk($sformatf("rst_out_valid%0d", id), 64'(ov), 64'd0);
            if (id == 0) q_a.delete(); else q_b.delete();
            prev_hold[id] = 1'b0;
        end else begin
            if (prev_hold[id]) begin
                chk($sformatf("hold_valid%0d", id), 64'(ov), 64'd1);
                chk($sformatf("hold_data%0d", id), 64'({e, d}), 64'(prev_data[id]));
            end
            if (ov && out_ready) begin
                out_cnt[id]++;
                if ((id == 0 && q_a.size() == 0) || (id == 1 && q_b.size() == 0)) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_out%0d: got %h expected no transfer", id, {e, d});
                end else begin
                    if (id == 0) exp = q_a.pop_front(); else exp = q_b.pop_front();
                    total++;
                    if ({e, d} !== exp) begin
                        bad++;
                        $display("FAIL out%0d: got %h expected %h", id, {e, d}, exp);
                    end
                    $display("out%0d #%0d value=%h err=%b", id, out_cnt[id], d, e);
                end
            end
            if (iv && ir) begin
                if (id == 0) q_a.push_back(ref_ext(ext_mode, imm, pc_hi));
                else         q_b.push_back(ref_ext(ext_mode, imm, pc_hi));
            end
            prev_hold[id] = ov && !out_ready;
            prev_data[id] = {e, d};
        end
    endtask

    task automatic mon_all();
        mon_one(0, bus_a.in_valid, bus_a.in_ready, bus_a.out_valid, bus_a.ImExtend, bus_a.ModeErr);
        mon_one(1, bus_b.in_valid, bus_b.in_ready, bus_b.out_valid, bus_b.ImExtend, bus_b.ModeErr);
    endtask

    // Inputs are set at the falling edge; settle, observe, then advance.
    task automatic cycle();
        #1;
        mon_all();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int   base_a;
        int   base_b;
        logic acc;
        logic pending;

        prev_hold[0] = 1'b0; prev_hold[1] = 1'b0;
        prev_data[0] = '0;   prev_data[1] = '0;
        out_cnt[0] = 0;      out_cnt[1] = 0;

        vecs[0]  = '{EXT_ZERO,   26'h0008004, 4'h0, 32'h00008004, 1'b0};
        vecs[1]  = '{EXT_SIGN,   26'h0008004, 4'h0, 32'hFFFF8004, 1'b0};
        vecs[2]  = '{EXT_UPPER,  26'h0008004, 4'h0, 32'h80040000, 1'b0};
        vecs[3]  = '{EXT_BRANCH, 26'h0008004, 4'h0, 32'hFFFE0010, 1'b0};
        vecs[4]  = '{EXT_JUMP,   26'h0000010, 4'h4, 32'h40000040, 1'b0};
        vecs[5]  = '{3'd6,       26'h0008004, 4'h4, 32'h00000000, 1'b1};
        vecs[6]  = '{EXT_ZERO,   26'h0001234, 4'h0, 32'h00001234, 1'b0};
        vecs[7]  = '{EXT_BRANCH, 26'h0007FFF, 4'h0, 32'h0001FFFC, 1'b0};
        vecs[8]  = '{3'd7,       26'h3FFFFFF, 4'hF, 32'h00000000, 1'b1};
        vecs[9]  = '{EXT_SIGN,   26'h2340001, 4'h0, 32'h00000001, 1'b0};
        vecs[10] = '{EXT_JUMP,   26'h3FFFFFF, 4'hF, 32'hFFFFFFFC, 1'b0};
        vecs[11] = '{EXT_UPPER,  26'h000FFFF, 4'h0, 32'hFFFF0000, 1'b0};

        // T1: reset held with a request pending.
        Reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        ext_mode = EXT_ZERO; imm = 26'h0000055; pc_hi = 4'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            #1;
            chk("t1_out_valid_a", 64'(bus_a.out_valid), 64'd0);
            chk("t1_in_ready_a", 64'(bus_a.in_ready), 64'd0);
            chk("t1_imext_a", 64'(bus_a.ImExtend), 64'd0);
            chk("t1_moderr_a", 64'(bus_a.ModeErr), 64'd0);
            chk("t1_in_ready_b", 64'(bus_b.in_ready), 64'd0);
        end
        @(negedge CLK);
        Reset = 1'b0; in_valid = 1'b0;
        #1;
        chk("t1_rel_in_ready_a", 64'(bus_a.in_ready), 64'd1);
        chk("t1_rel_in_ready_b", 64'(bus_b.in_ready), 64'd1);
        @(posedge CLK);
        @(negedge CLK);

        // T2/T3: table of modes, one per cycle, latency 1, no bubbles.
        for (int i = 0; i <= NV; i++) begin
            if (i < NV) begin
                in_valid = 1'b1;
                ext_mode = vecs[i].mode;
                imm      = vecs[i].imm;
                pc_hi    = vecs[i].pc;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (i < NV) chk($sformatf("vec%0d_in_ready", i), 64'(bus_a.in_ready), 64'd1);
            if (i > 0) begin
                chk($sformatf("vec%0d_valid_a", i-1), 64'(bus_a.out_valid), 64'd1);
                chk($sformatf("vec%0d_val_a", i-1), 64'(bus_a.ImExtend), 64'(vecs[i-1].val));
                chk($sformatf("vec%0d_err_a", i-1), 64'(bus_a.ModeErr), 64'(vecs[i-1].err));
                chk($sformatf("vec%0d_val_b", i-1), 64'(bus_b.ImExtend), 64'(vecs[i-1].val));
                chk($sformatf("vec%0d_err_b", i-1), 64'(bus_b.ModeErr), 64'(vecs[i-1].err));
            end
            mon_all();
            @(posedge CLK);
            @(negedge CLK);
        end
        #1;
        chk("t2_idle_valid_a", 64'(bus_a.out_valid), 64'd0);
        @(negedge CLK);

        // T4: backpressure, three requests offered with out_ready low.
        base_a = out_cnt[0];
        out_ready = 1'b0; in_valid = 1'b1; ext_mode = EXT_ZERO; pc_hi = 4'h0;
        imm = 26'h0000001;
        #1;
        chk("t4_rdy1_a", 64'(bus_a.in_ready), 64'd1);
        chk("t4_rdy1_b", 64'(bus_b.in_ready), 64'd1);
        mon_all(); @(posedge CLK); @(negedge CLK);
        imm = 26'h0000002;
        #1;
        chk("t4_rdy2_a", 64'(bus_a.in_ready), 64'd1);
        chk("t4_rdy2_b", 64'(bus_b.in_ready), 64'd0);
        mon_all(); @(posedge CLK); @(negedge CLK);
        imm = 26'h0000003;
        #1;
        chk("t4_rdy3_a", 64'(bus_a.in_ready), 64'd0);
        chk("t4_head_a", 64'(bus_a.ImExtend), 64'h1);
        mon_all(); @(posedge CLK); @(negedge CLK);
        out_ready = 1'b1;
        acc = 1'b0;
        for (int k = 0; k < 8 && !acc; k++) begin
            #1;
            acc = bus_a.in_ready;
            mon_all();
            @(posedge CLK);
            @(negedge CLK);
        end
        chk("t4_third_accepted", 64'(acc), 64'd1);
        in_valid = 1'b0;
        repeat (4) cycle();
        chk("t4_out_count_a", 64'(out_cnt[0] - base_a), 64'd3);
        chk("t4_drained_a", 64'(q_a.size()), 64'd0);

        // T5: streaming, 20 requests back to back.
        base_a = out_cnt[0];
        base_b = out_cnt[1];
        for (int k = 0; k <= 20; k++) begin
            if (k < 20) begin
                in_valid = 1'b1;
                ext_mode = 3'(k % 5);
                imm      = 26'($urandom);
                pc_hi    = 4'(k);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (k < 20) begin
                chk($sformatf("t5_rdy%0d_a", k), 64'(bus_a.in_ready), 64'd1);
                chk($sformatf("t5_rdy%0d_b", k), 64'(bus_b.in_ready), 64'd1);
            end
            if (k > 0) begin
                chk($sformatf("t5_valid%0d_a", k), 64'(bus_a.out_valid), 64'd1);
                chk($sformatf("t5_valid%0d_b", k), 64'(bus_b.out_valid), 64'd1);
            end
            mon_all();
            @(posedge CLK);
            @(negedge CLK);
        end
        chk("t5_count_a", 64'(out_cnt[0] - base_a), 64'd20);
        chk("t5_count_b", 64'(out_cnt[1] - base_b), 64'd20);

        // T6: reset with both entries full, then a random-stall run.
        out_ready = 1'b0; in_valid = 1'b1; ext_mode = EXT_SIGN;
        imm = 26'h000AAAA;
        cycle();
        imm = 26'h000BBBB;
        cycle();
        #1;
        chk("t6_full_rdy_a", 64'(bus_a.in_ready), 64'd0);
        @(negedge CLK);
        Reset = 1'b1; in_valid = 1'b0;
        #1;
        chk("t6_rst_valid_a", 64'(bus_a.out_valid), 64'd0);
        mon_all(); @(posedge CLK); @(negedge CLK);
        Reset = 1'b0;
        #1;
        chk("t6_post_valid_a", 64'(bus_a.out_valid), 64'd0);
        chk("t6_post_valid_b", 64'(bus_b.out_valid), 64'd0);
        chk("t6_post_imext_a", 64'(bus_a.ImExtend), 64'd0);
        mon_all(); @(posedge CLK); @(negedge CLK);
        out_ready = 1'b1;
        repeat (3) cycle();

        pending = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (!pending) begin
                in_valid = 1'($urandom_range(0, 1));
                ext_mode = 3'($urandom_range(0, 7));
                imm      = 26'($urandom);
                pc_hi    = 4'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            mon_all();
            pending = in_valid && !bus_a.in_ready;
            @(posedge CLK);
            @(negedge CLK);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 20 && (q_a.size() != 0 || q_b.size() != 0); k++) cycle();
        chk("t6_final_empty_a", 64'(q_a.size()), 64'd0);
        chk("t6_final_empty_b", 64'(q_b.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
